// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared types, limits and timer sizing for the button conditioning path
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HOLD      = 2'd2,
        REL_CHK   = 2'd3
    } btn_state_t;

    localparam int DEBOUNCE_MIN = 2;
    localparam int DEBOUNCE_MAX = 65535;
    localparam int REPEAT_MIN   = 2;
    localparam int REPEAT_MAX   = 65535;

    function automatic int clamp_range(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // One extra bit beyond the largest limit so the saturating timer never aliases a limit value.
    function automatic int tmr_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for raw board inputs
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/btn_debounce_pulse.sv
// rtl/btn_debounce_pulse.sv - debounced push-button to single-cycle count-enable strobes
module btn_debounce_pulse
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic pulse,
    output logic btn_level,
    output logic busy
);

    // Out-of-range parameters are pulled to the nearest legal value.
    localparam int DEB  = clamp_range(DEBOUNCE_CYCLES, DEBOUNCE_MIN, DEBOUNCE_MAX);
    localparam int RDLY = clamp_range(REPEAT_DELAY, REPEAT_MIN, REPEAT_MAX);
    localparam int RPER = clamp_range(REPEAT_PERIOD, REPEAT_MIN, REPEAT_MAX);
    localparam int TW   = tmr_width(DEB, RDLY, RPER);

    localparam logic [TW-1:0] DEB_LAST  = TW'(DEB - 1);
    localparam logic [TW-1:0] RDLY_LAST = TW'(RDLY - 1);
    localparam logic [TW-1:0] RPER_LAST = TW'(RPER - 1);
    localparam logic [TW-1:0] TMR_MAX   = {TW{1'b1}};

    logic            s2;
    btn_state_t      state;
    logic [TW-1:0]   tmr;
    logic [TW-1:0]   tmr_inc;
    logic [TW-1:0]   rep_last;
    logic            first_rep;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (s2)
    );

    assign tmr_inc  = (tmr == TMR_MAX) ? tmr : tmr + TW'(1);
    assign rep_last = first_rep ? RDLY_LAST : RPER_LAST;
    assign busy     = (state == PRESS_CHK) || (state == REL_CHK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tmr       <= '0;
            first_rep <= 1'b1;
            pulse     <= 1'b0;
            btn_level <= 1'b0;
        end else begin
            pulse <= 1'b0;
            case (state)
                IDLE: begin
                    btn_level <= 1'b0;
                    if (s2) begin
                        state <= PRESS_CHK;
                        tmr   <= TW'(1);
                    end
                end
                PRESS_CHK: begin
                    if (!s2) begin
                        state <= IDLE;
                    end else if (tmr == DEB_LAST) begin
                        state     <= HOLD;
                        pulse     <= 1'b1;
                        btn_level <= 1'b1;
                        tmr       <= '0;
                        first_rep <= 1'b1;
                    end else begin
                        tmr <= tmr_inc;
                    end
                end
                HOLD: begin
                    if (!s2) begin
                        state <= REL_CHK;
                        tmr   <= TW'(1);
                    end else if (REPEAT_EN != 0) begin
                        if (tmr == rep_last) begin
                            pulse     <= 1'b1;
                            tmr       <= '0;
                            first_rep <= 1'b0;
                        end else begin
                            tmr <= tmr_inc;
                        end
                    end
                end
                REL_CHK: begin
                    // Bounce on release re-arms the repeat delay but never strobes.
                    if (s2) begin
                        state     <= HOLD;
                        tmr       <= '0;
                        first_rep <= 1'b1;
                    end else if (tmr == DEB_LAST) begin
                        state     <= IDLE;
                        btn_level <= 1'b0;
                        tmr       <= '0;
                    end else begin
                        tmr <= tmr_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// tb/tb_btn_debounce_pulse.sv - directed self-checking bench for btn_debounce_pulse
module tb_btn_debounce_pulse;

    logic clk = 1'b0;
    logic reset;
    logic btn_in;
    logic pulse0, level0, busy0;
    logic pulse1, level1, busy1;

    int tests = 0;
    int failures = 0;
    int pc = 0;
    int pc_rep = 0;
    logic lvl_seen = 1'b0;
    logic [1:0] cnt;

    always #5 clk = ~clk;

    btn_debounce_pulse #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_EN       (0),
        .REPEAT_DELAY    (8),
        .REPEAT_PERIOD   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_in    (btn_in),
        .pulse     (pulse0),
        .btn_level (level0),
        .busy      (busy0)
    );

    btn_debounce_pulse #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_EN       (1),
        .REPEAT_DELAY    (8),
        .REPEAT_PERIOD   (4)
    ) dut_rep (
        .clk       (clk),
        .reset     (reset),
        .btn_in    (btn_in),
        .pulse     (pulse1),
        .btn_level (level1),
        .busy      (busy1)
    );

    always @(negedge clk) begin
        if (pulse0) pc = pc + 1;
        if (pulse1) pc_rep = pc_rep + 1;
        if (level0) lvl_seen = 1'b1;
    end

    // 2-bit counter stepped by the count-enable strobe
    always @(posedge clk) begin
        if (reset) cnt <= 2'd0;
        else if (pulse0) cnt <= cnt + 2'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests = tests + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int pc0;
        int pcr0;
        logic [31:0] mask;
        int runs [10] = '{1, 2, 3, 1, 3, 2, 1, 2, 3, 2};
        logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        reset  = 1'b1;
        btn_in = 1'b0;
        ticks(3);
        check("rst_pulse", pulse0, 0);
        check("rst_level", level0, 0);
        check("rst_busy", busy0, 0);
        check("rst_rep_pulse", pulse1, 0);

        // clean press: first sampled at edge E, strobe after E+5
        reset = 1'b0;
        ticks(2);
        btn_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("press_wait_pulse", pulse0, 0);
            if (k == 2) check("press_busy", busy0, 1);
        end
        tick();
        check("press_pulse", pulse0, 1);
        check("press_level", level0, 1);
        check("press_busy_done", busy0, 0);
        tick();
        check("press_pulse_one", pulse0, 0);
        check("press_count", pc, 1);

        // release bounce: low 2, high 3, then low steady
        btn_in = 1'b0;
        ticks(2);
        btn_in = 1'b1;
        ticks(3);
        btn_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rel_level_held", level0, 1);
        end
        tick();
        check("rel_level_fall", level0, 0);
        check("rel_no_extra_pulse", pc, 1);
        ticks(4);

        // bounce rejection
        pc0 = pc;
        pcr0 = pc_rep;
        lvl_seen = 1'b0;
        for (int r = 0; r < 10; r++) begin
            btn_in = (r % 2 == 0);
            ticks(runs[r]);
        end
        btn_in = 1'b0;
        ticks(8);
        check("bounce_pulses", pc - pc0, 0);
        check("bounce_rep_pulses", pc_rep - pcr0, 0);
        check("bounce_level", lvl_seen, 0);

        // auto-repeat
        pc0 = pc;
        btn_in = 1'b1;
        ticks(5);
        tick();
        check("rep_press_pulse", pulse1, 1);
        mask = '0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (pulse1) mask[k] = 1'b1;
        end
        check("rep_mask", mask, 32'h1111_1100);
        check("rep_plain_single", pc - pc0, 1);
        btn_in = 1'b0;
        ticks(10);

        // reset two cycles into PRESS_CHK
        btn_in = 1'b1;
        ticks(4);
        check("mid_busy", busy0, 1);
        reset = 1'b1;
        tick();
        check("mid_rst_pulse", pulse0, 0);
        check("mid_rst_busy", busy0, 0);
        check("mid_rst_level", level0, 0);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("post_rst_wait", pulse0, 0);
        end
        tick();
        check("post_rst_pulse", pulse0, 1);
        ticks(7);
        tick();
        check("hold_rep_first", pulse1, 1);
        ticks(2);
        reset = 1'b1;
        tick();
        check("hold_rst_pulse", pulse1, 0);
        check("hold_rst_level", level1, 0);
        check("hold_rst_busy", busy1, 0);
        reset = 1'b0;
        pcr0 = pc_rep;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("hold_post_wait", pulse1, 0);
        end
        tick();
        check("hold_post_pulse", pulse1, 1);
        check("hold_post_count", pc_rep - pcr0, 0);
        btn_in = 1'b0;
        ticks(12);

        // counter hookup
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("cnt_reset", cnt, 0);
        for (int i = 0; i < 5; i++) begin
            btn_in = 1'b1;
            ticks(8);
            btn_in = 1'b0;
            ticks(8);
            check("cnt_seq", cnt, exp_cnt[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/btn_debounce_pulse.md
# btn_debounce_pulse

Input-conditioning stage in front of the 2-bit T-flip-flop counter. It takes a raw, asynchronous, bouncing push-button level, synchronises and debounces it, and emits single-cycle `pulse` strobes that drive the counter's count-enable. It includes an optional hold-to-auto-repeat mode so a held button keeps stepping the counter.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronised samples required to accept a level change; legal range 2..65535.
- `REPEAT_EN`, default 0: 1 enables auto-repeat while the button is held; 0 gives exactly one pulse per press.
- `REPEAT_DELAY`, default 8: cycles from the press pulse to the first repeat pulse; must be ≥2.
- `REPEAT_PERIOD`, default 4: cycles between successive repeat pulses; must be ≥2.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high; sampled on the rising `clk` edge.
- `btn_in`  input  1  raw button level, asynchronous to `clk`, active-high.
- `pulse`  output  1  one-cycle strobe per accepted press and per repeat; registered.
- `btn_level`  output  1  debounced button level; registered.
- `busy`  output  1  high while a level change is being qualified (PRESS_CHK or REL_CHK).

## Operation
- Synchroniser: two flops `s1`, `s2`. The `s2` value is the only version of `btn_in` used by the logic below.
- Single timer `tmr` is shared by all states. Its width is clog2 of max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1.
- FSM states: IDLE, PRESS_CHK, HOLD, REL_CHK.
  - IDLE: `btn_level`=0. If `s2`=1, go to PRESS_CHK with `tmr`=1.
  - PRESS_CHK:
    - If `s2`=0, return to IDLE.
    - Else if `tmr`=DEBOUNCE_CYCLES-1, go to HOLD, assert `pulse`, set `btn_level`=1, `tmr`=0.
    - Else increment `tmr`.
  - HOLD:
    - If `s2`=0, go to REL_CHK with `tmr`=1.
    - Else if REPEAT_EN=1, increment `tmr`. On reaching REPEAT_DELAY-1 for the first repeat, or REPEAT_PERIOD-1 for later repeats, assert `pulse` and clear `tmr`. A one-bit flag `first_rep` selects which limit applies.
  - REL_CHK:
    - If `s2`=1, return to HOLD with `tmr`=0 and `first_rep`=1. A bounce on release never produces a pulse.
    - Else if `tmr`=DEBOUNCE_CYCLES-1, go to IDLE with `btn_level`=0.
    - Else increment `tmr`.
- `pulse` is never high on two consecutive cycles.
- `tmr` saturates at its limit and does not wrap.
- Reset values: `s1`=`s2`=0, state=IDLE, `tmr`=0, `first_rep`=1. Outputs `pulse`=0, `btn_level`=0, `busy`=0.

## Timing
- Press latency: `btn_in` first sampled high at edge n and held → `pulse` high for exactly the cycle following edge n+1+DEBOUNCE_CYCLES. With the default of 4, that is edge n+5.
- `btn_level` rises on the same edge as the press `pulse`.
- Release latency: `btn_level` falls DEBOUNCE_CYCLES+1 edges after `btn_in` is first sampled low.
- Glitch rejection: any `s2` run shorter than DEBOUNCE_CYCLES cycles causes no output change.
- Repeat timing with REPEAT_EN=1: first repeat pulse REPEAT_DELAY cycles after the press pulse, then one pulse every REPEAT_PERIOD cycles.
- Reset asserted at any edge, including mid-qualification or mid-repeat, gives all reset values on that edge, so `pulse` is 0 in the following cycle. Reset takes precedence over every FSM transition.
- `btn_in` high during and after reset deassertion is treated as a new press: full synchroniser plus debounce latency, then one `pulse`.

## Structure
- Shared package `btn_pkg` holds:
  - the FSM state enum (IDLE, PRESS_CHK, HOLD, REL_CHK);
  - the `tmr` width helper function;
  - parameter range-check constants.
- Sub-module `sync_2ff`: a 2-flop synchroniser with synchronous reset, reused for the other raw board inputs.
- Everything else stays in the top-level FSM and timer.

## Test plan
- Reset, then press: reset 3 cycles, then `btn_in`=1 steady at edge 10 (DEBOUNCE_CYCLES=4) → `pulse` high only in the cycle after edge 15; `btn_level`=1 from edge 15; exactly 1 pulse total.
- Bounce rejection: `btn_in` toggles 1,0,1,0 with 1–3 cycle runs for 20 cycles, then stays 0 → zero pulses; `btn_level` stays 0.
- Release bounce: held press, then `btn_in` low for 2 cycles, high for 3, low steady → no extra pulse; `btn_level` falls 5 edges after the final low is first sampled.
- Auto-repeat (REPEAT_EN=1, REPEAT_DELAY=8, REPEAT_PERIOD=4), held 30 cycles past the press pulse → pulses at +0, +8, +12, +16, +20, +24, +28.
- Reset mid-operation: reset asserted 2 cycles into PRESS_CHK, and again during HOLD with repeat active → all outputs 0 after that edge; no pulse until a fresh full qualification.
- Counter hookup: `pulse` drives the counter's toggle enable; 5 clean presses → counter sequence 1,2,3,0,1.
